// File: rtl/dragon_pkg.sv
// Shared constants, types and tile helpers for the dragon head/body pipeline.
package dragon_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] HIDDEN_POS = 8'hFB;

  localparam int unsigned DEFAULT_GRID_W      = 16;
  localparam int unsigned DEFAULT_GRID_H      = 12;
  localparam int unsigned DEFAULT_MOVE_PERIOD = 10;
  localparam int unsigned DEFAULT_STUN_STEPS  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StChase,
    StStun
  } dragon_state_e;

  typedef struct packed {
    logic       in_grid;
    logic [7:0] pos;
  } tile_step_t;

  function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

  // Bounds are checked in 5-bit signed space so a step off row/column 0 is caught.
  function automatic tile_step_t step_tile(input logic [1:0]        dir,
                                           input logic [7:0]        pos,
                                           input logic signed [4:0] max_x,
                                           input logic signed [4:0] max_y);
    logic signed [4:0] x;
    logic signed [4:0] y;
    tile_step_t        r;
    x = {1'b0, pos[3:0]};
    y = {1'b0, pos[7:4]};
    case (dir)
      DIR_UP:    y = y - 5'sd1;
      DIR_RIGHT: x = x + 5'sd1;
      DIR_DOWN:  y = y + 5'sd1;
      default:   x = x - 5'sd1;
    endcase
    r.in_grid = (x >= 5'sd0) && (x <= max_x) && (y >= 5'sd0) && (y <= max_y);
    r.pos     = {y[3:0], x[3:0]};
    return r;
  endfunction

endpackage

// File: rtl/dragon_steer.sv
// Combinational steering: picks the next head tile and direction toward the target.
module dragon_steer
  import dragon_pkg::*;
#(
  parameter int unsigned GRID_W = DEFAULT_GRID_W,
  parameter int unsigned GRID_H = DEFAULT_GRID_H
) (
  input  logic [7:0] head_pos,
  input  logic [1:0] head_dir,
  input  logic [7:0] target_pos,
  output logic [7:0] next_pos,
  output logic [1:0] next_dir,
  output logic       move_valid
);

  localparam logic signed [4:0] MaxX = 5'(GRID_W - 1);
  localparam logic signed [4:0] MaxY = 5'(GRID_H - 1);

  logic signed [4:0] hx, hy, tx, ty;
  logic signed [4:0] dx, dy, adx, ady;
  logic              x_primary;
  logic              sec_nonzero;
  logic              target_in_grid;
  logic [1:0]        prim_dir, sec_dir, chosen_dir, alt_dir;
  tile_step_t        chosen_step, alt_step;

  assign hx = {1'b0, head_pos[3:0]};
  assign hy = {1'b0, head_pos[7:4]};
  assign tx = {1'b0, target_pos[3:0]};
  assign ty = {1'b0, target_pos[7:4]};
  assign dx = tx - hx;
  assign dy = ty - hy;
  assign adx = dx[4] ? -dx : dx;
  assign ady = dy[4] ? -dy : dy;

  assign target_in_grid = (tx <= MaxX) && (ty <= MaxY);

  always_comb begin
    x_primary   = (adx >= ady);
    prim_dir    = x_primary ? (dx[4] ? DIR_LEFT : DIR_RIGHT) : (dy[4] ? DIR_UP : DIR_DOWN);
    sec_dir     = x_primary ? (dy[4] ? DIR_UP : DIR_DOWN) : (dx[4] ? DIR_LEFT : DIR_RIGHT);
    sec_nonzero = x_primary ? (dy != 5'sd0) : (dx != 5'sd0);

    chosen_dir = prim_dir;
    if (prim_dir == reverse_dir(head_dir)) begin
      if (sec_nonzero) begin
        chosen_dir = sec_dir;
      end else if (target_in_grid) begin
        chosen_dir = head_dir + 2'd1;
      end else begin
        chosen_dir = head_dir - 2'd1;
      end
    end

    // A sideways choice falls back to the opposite side; a straight one to the clockwise side.
    if (chosen_dir[0] != head_dir[0]) begin
      alt_dir = reverse_dir(chosen_dir);
    end else begin
      alt_dir = head_dir + 2'd1;
    end

    chosen_step = step_tile(chosen_dir, head_pos, MaxX, MaxY);
    alt_step    = step_tile(alt_dir, head_pos, MaxX, MaxY);

    move_valid = 1'b0;
    next_pos   = head_pos;
    next_dir   = head_dir;
    if ((target_pos != HIDDEN_POS) && ((dx != 5'sd0) || (dy != 5'sd0))) begin
      if (chosen_step.in_grid) begin
        move_valid = 1'b1;
        next_pos   = chosen_step.pos;
        next_dir   = chosen_dir;
      end else if (alt_step.in_grid) begin
        move_valid = 1'b1;
        next_pos   = alt_step.pos;
        next_dir   = alt_dir;
      end
    end
  end

endmodule

// File: rtl/dragon_head_controller.sv
// Dragon head stage: frame-tick movement counter, chase/stun FSM and the head word.
module dragon_head_controller
  import dragon_pkg::*;
#(
  parameter int unsigned MOVE_PERIOD = DEFAULT_MOVE_PERIOD,
  parameter int unsigned STUN_STEPS  = DEFAULT_STUN_STEPS,
  parameter logic [7:0]  SPAWN_POS   = 8'h00,
  parameter int unsigned GRID_W      = DEFAULT_GRID_W,
  parameter int unsigned GRID_H      = DEFAULT_GRID_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       hit,
  input  logic [7:0] target_pos,
  output logic [9:0] dragon_head,
  output logic [5:0] movement_counter,
  output logic       step_pulse,
  output logic       stunned
);

  localparam int unsigned StunW = (STUN_STEPS < 2) ? 1 : $clog2(STUN_STEPS + 1);

  dragon_state_e    state_q;
  logic [9:0]       head_q;
  logic [5:0]       counter_q;
  logic [StunW-1:0] stun_cnt_q;
  logic             vsync_q, hit_q;
  logic             step_pulse_q, stunned_q;

  logic             frame_tick, step, hit_edge;
  logic [7:0]       steer_pos;
  logic [1:0]       steer_dir;
  logic             steer_valid;

  assign frame_tick = vsync & ~vsync_q;
  assign step       = frame_tick && (counter_q == 6'(MOVE_PERIOD));
  assign hit_edge   = hit & ~hit_q;

  dragon_steer #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_steer (
    .head_pos  (head_q[7:0]),
    .head_dir  (head_q[9:8]),
    .target_pos(target_pos),
    .next_pos  (steer_pos),
    .next_dir  (steer_dir),
    .move_valid(steer_valid)
  );

  // Counter advances on the same edge the body stage shifts, so the body sees the pre-step head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_q      <= 1'b0;
      hit_q        <= 1'b0;
      counter_q    <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      hit_q        <= hit;
      step_pulse_q <= step;
      if (frame_tick) begin
        counter_q <= step ? 6'd0 : counter_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      head_q     <= {DIR_UP, HIDDEN_POS};
      stun_cnt_q <= '0;
      stunned_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (step && start) begin
            head_q  <= {DIR_RIGHT, SPAWN_POS};
            state_q <= StChase;
          end
        end
        StChase: begin
          if (step && steer_valid) begin
            head_q <= {steer_dir, steer_pos};
          end
          if (hit_edge) begin
            stun_cnt_q <= StunW'(STUN_STEPS);
            stunned_q  <= 1'b1;
            state_q    <= StStun;
          end
        end
        StStun: begin
          if (step) begin
            if (stun_cnt_q <= StunW'(1)) begin
              stun_cnt_q <= '0;
              stunned_q  <= 1'b0;
              state_q    <= StChase;
            end else begin
              stun_cnt_q <= stun_cnt_q - StunW'(1);
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          stunned_q <= 1'b0;
        end
      endcase
    end
  end

  assign dragon_head      = head_q;
  assign movement_counter = counter_q;
  assign step_pulse       = step_pulse_q;
  assign stunned          = stunned_q;

endmodule

// File: tb/tb_dragon_head_controller.sv
// Directed bench for dragon_head_controller with a step-indexed head scoreboard.
module tb_dragon_head_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       start;
  logic       hit;
  logic [7:0] target_pos;
  logic [9:0] dragon_head;
  logic [5:0] movement_counter;
  logic       step_pulse;
  logic       stunned;

  int         n_vec = 0;
  int         n_fail = 0;
  int         pulse_cnt = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_head;

  always #5 clk = ~clk;

  dragon_head_controller dut (
    .clk             (clk),
    .reset           (reset),
    .vsync           (vsync),
    .start           (start),
    .hit             (hit),
    .target_pos      (target_pos),
    .dragon_head     (dragon_head),
    .movement_counter(movement_counter),
    .step_pulse      (step_pulse),
    .stunned         (stunned)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Head word is compared once per step, in the cycle step_pulse is high.
  always @(negedge clk) begin
    if (reset === 1'b1 && step_pulse === 1'b1) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $error("FAIL unexpected_step: observed head %h with no step expected", dragon_head);
      end else begin
        exp_head = sb.pop_front();
        check("head_at_step", {6'd0, dragon_head}, {6'd0, exp_head});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic frame();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic step_once(input logic [9:0] exp);
    sb.push_back(exp);
    repeat (11) frame();
    check("sb_drained", 16'(sb.size()), 16'd0);
  endtask

  task automatic pulse_hit();
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    vsync      = 1'b0;
    start      = 1'b0;
    hit        = 1'b0;
    target_pos = 8'hFB;
    repeat (3) @(negedge clk);
    check("rst_head", {6'd0, dragon_head}, 16'h00FB);
    check("rst_counter", {10'd0, movement_counter}, 16'd0);
    check("rst_step_pulse", {15'd0, step_pulse}, 16'd0);
    check("rst_stunned", {15'd0, stunned}, 16'd0);
    reset = 1'b1;

    // Idle: counter runs 1..10 then wraps, one step with head hidden.
    sb.push_back(10'h0FB);
    for (int i = 1; i <= 11; i++) begin
      frame();
      check("idle_counter", {10'd0, movement_counter}, 16'(i % 11));
      check("idle_head", {6'd0, dragon_head}, 16'h00FB);
    end
    check("idle_pulses", 16'(pulse_cnt), 16'd1);
    check("idle_sb_drained", 16'(sb.size()), 16'd0);

    // Spawn and straight run along row 0.
    start      = 1'b1;
    target_pos = 8'h03;
    step_once(10'h100);
    step_once(10'h101);
    step_once(10'h102);
    step_once(10'h103);
    step_once(10'h103);

    // Reversal with zero dy turns clockwise (down), then walk to 0x01.
    target_pos = 8'h01;
    step_once(10'h213);
    step_once(10'h312);
    step_once(10'h311);
    step_once(10'h001);
    step_once(10'h001);

    target_pos = 8'h00;
    step_once(10'h300);
    step_once(10'h300);
    target_pos = 8'hFB;
    step_once(10'h300);

    // Clockwise turn would leave the grid at row 0: take the other side (down).
    target_pos = 8'h02;
    step_once(10'h210);

    target_pos = 8'h56;
    step_once(10'h111);
    step_once(10'h112);
    step_once(10'h113);
    step_once(10'h223);
    step_once(10'h124);
    step_once(10'h234);
    step_once(10'h135);
    step_once(10'h245);
    step_once(10'h146);
    step_once(10'h256);
    target_pos = 8'h55;
    step_once(10'h355);
    target_pos = 8'h57;
    step_once(10'h045);

    // Off-grid target with blocked reversal: counter-clockwise turn.
    target_pos = 8'hC5;
    step_once(10'h344);

    // Stun for three steps; a second hit does not reload.
    target_pos = 8'h42;
    pulse_hit();
    check("stun_enter", {15'd0, stunned}, 16'd1);
    step_once(10'h344);
    pulse_hit();
    check("stun_step1", {15'd0, stunned}, 16'd1);
    step_once(10'h344);
    check("stun_step2", {15'd0, stunned}, 16'd1);
    step_once(10'h344);
    check("stun_exit", {15'd0, stunned}, 16'd0);
    step_once(10'h343);

    // Reset on a frame tick while stunned.
    pulse_hit();
    check("stun_again", {15'd0, stunned}, 16'd1);
    repeat (5) frame();
    check("pre_reset_counter", {10'd0, movement_counter}, 16'd5);
    @(negedge clk);
    vsync = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b0;
    start = 1'b0;
    check("mid_rst_head", {6'd0, dragon_head}, 16'h00FB);
    check("mid_rst_counter", {10'd0, movement_counter}, 16'd0);
    check("mid_rst_stunned", {15'd0, stunned}, 16'd0);
    check("mid_rst_step_pulse", {15'd0, step_pulse}, 16'd0);
    @(negedge clk);

    // Back in idle: hit is ignored and steps keep the head hidden.
    target_pos = 8'h33;
    pulse_hit();
    check("idle_hit_ignored", {15'd0, stunned}, 16'd0);
    step_once(10'h0FB);
    check("idle_after_reset", {15'd0, stunned}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dragon_head_controller.md
Name: dragon_head_controller

Overview:
- Upstream stage of the dragon body queue. Generates the dragon head word (orientation and position) and the shared movement frame counter that the body stage samples on vsync rising edges.
- Steers the head one grid tile per movement step toward the player's tile. Reversals are forbidden and the head stays inside the play grid.
- A hit freezes the head for a fixed number of steps.

Parameters:
- MOVE_PERIOD, 10, frame ticks per movement step; the step fires on the tick where movement_counter == MOVE_PERIOD.
- STUN_STEPS, 3, movement steps the head stays frozen after a hit.
- SPAWN_POS, 8'h00, tile the head takes on start.
- GRID_W, 16, grid columns (x 0..GRID_W-1).
- GRID_H, 12, grid rows (y 0..GRID_H-1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- vsync  input  1  frame sync from the VGA timing block
- start  input  1  level; leaves IDLE at the next movement step
- hit  input  1  level; rising edge stuns the head
- target_pos  input  8  player tile {y[7:4], x[3:0]}; 8'hFB = player hidden
- dragon_head  output  10  [9:8] orientation (00 up, 01 right, 10 down, 11 left), [7:0] tile {y,x}
- movement_counter  output  6  frame-tick counter, 0..MOVE_PERIOD
- step_pulse  output  1  one-clk pulse on the cycle the head register updates
- stunned  output  1  high while in STUN

Behaviour:
- Reset values (reset==0 at a clk edge):
  - dragon_head = {2'b00, 8'hFB} (hidden sentinel; row F is off-grid)
  - movement_counter = 0, step_pulse = 0, stunned = 0
  - state = IDLE, stun_cnt = 0
  - vsync and hit edge registers cleared
- Reset mid-operation overrides everything in that cycle; there is no partial update.
- Frame tick: one clk after vsync goes 0->1, detected by a registered previous vsync.
- Movement step, evaluated on each frame tick:
  - If movement_counter == MOVE_PERIOD: counter <= 0, step fires.
  - Otherwise: counter <= counter + 1.
  - The counter runs in all states.
- The head register and counter update on the same clk edge as the body stage's shift, so the body captures the pre-step head. This 1-step lag is intentional.
- step_pulse is high for exactly the clk cycle after that edge.
- Hit edge: hit & ~hit_q.
- States and transitions:
  - IDLE: head held at the hidden sentinel. On a step with start==1: head <= {01, SPAWN_POS}, go to CHASE.
  - CHASE: on each step, compute the move from dx = tx - hx and dy = ty - hy (signed 5-bit):
    - Primary axis is the one with the larger |d|; a tie goes to X. The direction is the sign of d on that axis.
    - If the primary direction is the reverse of the current orientation: use the secondary axis if its d != 0. Otherwise turn clockwise (orientation+1 mod 4) if the target tile is in-grid, else counter-clockwise.
    - If the chosen tile is out of grid (x<0, x>GRID_W-1, y<0, y>GRID_H-1), try the other perpendicular direction, then hold.
    - dx==0 and dy==0: hold position and orientation.
    - target_pos == 8'hFB: hold.
    - The orientation field always equals the direction of the last successful move.
  - Hit edge in CHASE: stun_cnt <= STUN_STEPS, go to STUN, stunned = 1, effective on the next clk.
  - STUN: on each step, position is held and stun_cnt is decremented. When a step finds stun_cnt == 1, stun_cnt <= 0 and the block returns to CHASE; the first CHASE move happens on the following step.
    - Hit edges during STUN are ignored (no reload).
    - A hit edge in IDLE is ignored.
- Simultaneous hit edge and step in CHASE: the move is applied, then the block enters STUN.
- start is only sampled in IDLE. The only way back to IDLE is reset.
- Width rules:
  - x and y are 4-bit unsigned.
  - Differences are sign-extended to 5 bits.
  - Bound checks are done in 5-bit signed arithmetic before truncation.

Decomposition:
- Shared package (dragon_pkg):
  - orientation constants DIR_UP/RIGHT/DOWN/LEFT
  - HIDDEN_POS = 8'hFB
  - grid dimensions
  - the state enum (IDLE, CHASE, STUN)
  - the MOVE_PERIOD default, so the body stage compares against the same constant
- One combinational sub-module, dragon_steer. It takes head, orientation and target and returns the next tile and direction, plus a valid flag (0 = hold). The FSM, counter and edge detection stay in the top.

Test Plan:
- Reset, then 11 vsync pulses with start=0 → dragon_head stays 10'h0FB; movement_counter runs 0..10 and then wraps to 0 on the 11th tick; step_pulse fires once.
- start=1, target_pos=8'h03 → first step: head = {01, 8'h00}; the next three steps give 8'h01, 8'h02, 8'h03 (orientation 01); further steps hold at 8'h03.
- Head {11(left), 8'h55}, target 8'h57 → reversal blocked and dy=0, so clockwise turn up: head = {00, 8'h45}.
- Head {00, 8'h05} at top row, target 8'h05 minus... (use head {01, 8'h0F}, target 8'h0F hidden-free, orientation right and target 8'hFB) → hold. Head {00, 8'h00}, target 8'h00 → hold, orientation unchanged.
- hit pulse while in CHASE at 8'h22 → stunned=1; the next 3 steps hold at 8'h22; a second hit during STUN does not extend the stun; the 4th step moves again.
- Assert reset low mid-step during STUN → next cycle: dragon_head=10'h0FB, counter=0, stunned=0, state IDLE.
